mem_arb: RTL and testbench

Arbiter and sequencer for the single-port main memory in the SISC computer. Two requesters share the memory: instruction fetch (IF, driven in the fetch state) and data access (DM, driven in the mem state for LOD/STR/SWP). The block grants one requester at a time and drives the memory port for a fixed multi-cycle access. It returns read data with a one-cycle acknowledge and prevents fetch starvation.

---
 rtl/mem_arb.sv | 130 +++++++++++++
 tb/tb_mem_arb.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb.sv
// Arbiter/sequencer for the single-port SISC main memory: grants IF or DM,
// runs a fixed MEM_LAT-cycle access, then pulses the owner's ack for one cycle.
module mem_arb #(
   parameter int AW         = 16,
   parameter int DW         = 32,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_LIM = 3
) (
   input  logic          clk,
   input  logic          rst_f,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [DW-1:0] if_rdata,
   output logic          if_ack,
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic [DW-1:0] dm_rdata,
   output logic          dm_ack,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_t;

   localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);
   localparam logic [2:0] SLIM     = 3'(STARVE_LIM);

   state_t        state, state_nxt;
   owner_t        owner;
   logic [3:0]    lat_cnt;
   logic [2:0]    starve_cnt;
   logic [AW-1:0] addr_q;
   logic          we_q;
   logic [DW-1:0] wdata_q;
   logic          contested;
   logic          grant_if;
   logic          grant_dm;
   logic          last_cyc;

   function automatic logic [2:0] sat_inc(input logic [2:0] val);
      return (val >= SLIM) ? SLIM : val + 3'd1;
   endfunction

   // DM normally wins a tie; IF wins once it has lost STARVE_LIM times in a row
   always_comb begin
      contested = if_req & dm_req;
      grant_dm  = (state == IDLE) & dm_req & ~(if_req & (starve_cnt == SLIM));
      grant_if  = (state == IDLE) & if_req & ~grant_dm;
      last_cyc  = (state == ACCESS) & (lat_cnt == 4'd0);
   end

   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_if | grant_dm) state_nxt = ACCESS;
         ACCESS:  if (lat_cnt == 4'd0)     state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state != IDLE);
      mem_en    = (state == ACCESS);
      mem_we    = mem_en & we_q;
      mem_addr  = mem_en ? addr_q : '0;
      mem_wdata = mem_en ? wdata_q : '0;
      if_ack    = (state == DONE) & (owner == OWN_IF);
      dm_ack    = (state == DONE) & (owner == OWN_DM);
   end

   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         owner      <= OWN_NONE;
         lat_cnt    <= 4'd0;
         starve_cnt <= 3'd0;
      end else begin
         if (grant_if) begin
            owner      <= OWN_IF;
            lat_cnt    <= LAT_INIT;
            starve_cnt <= 3'd0;
         end else if (grant_dm) begin
            owner   <= OWN_DM;
            lat_cnt <= LAT_INIT;
            if (contested) starve_cnt <= sat_inc(starve_cnt);
         end else if (state == ACCESS && lat_cnt != 4'd0) begin
            lat_cnt <= lat_cnt - 4'd1;
         end else if (state == DONE) begin
            owner <= OWN_NONE;
         end
      end
   end

   // Request payload; only observed while ACCESS, so it needs no reset
   always_ff @(posedge clk) begin
      if (grant_if) begin
         addr_q  <= if_addr;
         we_q    <= 1'b0;
         wdata_q <= '0;
      end else if (grant_dm) begin
         addr_q  <= dm_addr;
         we_q    <= dm_we;
         wdata_q <= dm_wdata;
      end
   end

   // Read data lands only on the final access cycle; stores never touch dm_rdata
   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         if_rdata <= '0;
         dm_rdata <= '0;
      end else if (last_cyc) begin
         if (owner == OWN_IF)             if_rdata <= mem_rdata;
         else if (owner == OWN_DM && !we_q) dm_rdata <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: MEM_LAT=2 instance for most scenarios, plus a
// MEM_LAT=1 instance for the single-cycle-access case.
module tb_mem_arb;

   logic        clk = 1'b0;
   logic        rst_f = 1'b0;

   logic        if_req = 0, dm_req = 0, dm_we = 0;
   logic [15:0] if_addr = '0, dm_addr = '0;
   logic [31:0] dm_wdata = '0, rd_val = '0;
   logic [31:0] if_rdata, dm_rdata, mem_wdata, mem_rdata;
   logic        if_ack, dm_ack, mem_en, mem_we, busy;
   logic [15:0] mem_addr;
   int          en_cnt;

   logic        if_req1 = 0;
   logic [15:0] if_addr1 = '0;
   logic [31:0] rd_val1 = '0;
   logic [31:0] if_rdata1, dm_rdata1, mem_wdata1, mem_rdata1;
   logic        if_ack1, dm_ack1, mem_en1, mem_we1, busy1;
   logic [15:0] mem_addr1;
   int          en_cnt1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_arb #(.AW(16), .DW(32), .MEM_LAT(2), .STARVE_LIM(3)) u0 (
      .clk(clk), .rst_f(rst_f),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_ack(dm_ack),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy));

   mem_arb #(.AW(16), .DW(32), .MEM_LAT(1), .STARVE_LIM(3)) u1 (
      .clk(clk), .rst_f(rst_f),
      .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_ack(if_ack1),
      .dm_req(1'b0), .dm_we(1'b0), .dm_addr(16'h0), .dm_wdata(32'h0),
      .dm_rdata(dm_rdata1), .dm_ack(dm_ack1),
      .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
      .mem_rdata(mem_rdata1), .busy(busy1));

   // Memory model: read data is valid only on the last access cycle
   always @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         en_cnt  <= 0;
         en_cnt1 <= 0;
      end else begin
         en_cnt  <= mem_en  ? en_cnt + 1  : 0;
         en_cnt1 <= mem_en1 ? en_cnt1 + 1 : 0;
      end
   end
   assign mem_rdata  = (mem_en  && en_cnt  == 1) ? rd_val  : 32'h5A5A5A5A;
   assign mem_rdata1 = (mem_en1 && en_cnt1 == 0) ? rd_val1 : 32'hA5A5A5A5;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state
      #3;
      chk("rst_mem_en", mem_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_if_ack", if_ack, 0);
      chk("rst_dm_ack", dm_ack, 0);
      chk("rst_if_rdata", if_rdata, 0);
      chk("rst_dm_rdata", dm_rdata, 0);
      chk("rst_mem_addr", mem_addr, 0);
      step(); step();
      rst_f = 1'b1;
      step();
      chk("idle_busy", busy, 0);

      // IF alone
      if_req = 1; if_addr = 16'h0010; rd_val = 32'h88000001;
      step();
      chk("t1_c1_en", mem_en, 1);
      chk("t1_c1_we", mem_we, 0);
      chk("t1_c1_addr", mem_addr, 16'h0010);
      chk("t1_c1_busy", busy, 1);
      step();
      chk("t1_c2_en", mem_en, 1);
      chk("t1_c2_ack", if_ack, 0);
      step();
      chk("t1_c3_ack", if_ack, 1);
      chk("t1_c3_en", mem_en, 0);
      chk("t1_c3_busy", busy, 1);
      chk("t1_rdata", if_rdata, 32'h88000001);
      if_req = 0;
      step();
      chk("t1_c4_ack", if_ack, 0);
      chk("t1_c4_busy", busy, 0);

      // Both requesters at once: DM store first, then IF
      if_req = 1; if_addr = 16'h0020; rd_val = 32'h11112222;
      dm_req = 1; dm_we = 1; dm_addr = 16'h0040; dm_wdata = 32'hDEADBEEF;
      step();
      chk("t2_c1_we", mem_we, 1);
      chk("t2_c1_addr", mem_addr, 16'h0040);
      chk("t2_c1_wdata", mem_wdata, 32'hDEADBEEF);
      step();
      step();
      chk("t2_c3_dm_ack", dm_ack, 1);
      chk("t2_c3_if_ack", if_ack, 0);
      chk("t2_dm_rdata", dm_rdata, 0);
      dm_req = 0; dm_we = 0;
      step();
      chk("t2_c4_busy", busy, 0);
      step();
      chk("t2_c5_addr", mem_addr, 16'h0020);
      chk("t2_c5_we", mem_we, 0);
      step();
      step();
      chk("t2_c7_if_ack", if_ack, 1);
      chk("t2_if_rdata", if_rdata, 32'h11112222);
      if_req = 0;
      step();

      // Continuous contention: D D D I D D D I
      if_req = 1; if_addr = 16'h0200;
      dm_req = 1; dm_we = 0; dm_addr = 16'h0100; rd_val = 32'h0BADF00D;
      for (int k = 0; k < 8; k++) begin
         logic exp_if;
         exp_if = (k == 3 || k == 7);
         step();
         chk($sformatf("t3_g%0d_addr", k), mem_addr, exp_if ? 16'h0200 : 16'h0100);
         step();
         step();
         chk($sformatf("t3_g%0d_if_ack", k), if_ack, exp_if);
         chk($sformatf("t3_g%0d_dm_ack", k), dm_ack, !exp_if);
         step();
      end
      if_req = 0; dm_req = 0;
      step(); step();

      // DM load then DM store: store leaves dm_rdata alone
      dm_req = 1; dm_we = 0; dm_addr = 16'h0005; rd_val = 32'h0000ABCD;
      step();
      chk("t4_ld_addr", mem_addr, 16'h0005);
      step();
      step();
      chk("t4_ld_ack", dm_ack, 1);
      chk("t4_ld_rdata", dm_rdata, 32'h0000ABCD);
      dm_req = 0; rd_val = 32'hFFFF0000;
      step();
      dm_req = 1; dm_we = 1; dm_addr = 16'h0006; dm_wdata = 32'h12345678;
      step();
      chk("t4_st_we", mem_we, 1);
      chk("t4_st_wdata", mem_wdata, 32'h12345678);
      step();
      step();
      chk("t4_st_ack", dm_ack, 1);
      chk("t4_st_rdata", dm_rdata, 32'h0000ABCD);
      dm_req = 0; dm_we = 0;
      step();

      // Reset during an IF access
      if_req = 1; if_addr = 16'h0030; rd_val = 32'h77777777;
      step();
      chk("t5_c1_en", mem_en, 1);
      #2 rst_f = 0;
      #1;
      chk("t5_rst_en", mem_en, 0);
      chk("t5_rst_busy", busy, 0);
      step();
      chk("t5_rst_ack", if_ack, 0);
      chk("t5_rst_rdata", if_rdata, 0);
      #2 rst_f = 1;
      step();
      chk("t5_regrant_en", mem_en, 1);
      chk("t5_regrant_addr", mem_addr, 16'h0030);
      step();
      step();
      chk("t5_ack", if_ack, 1);
      chk("t5_rdata", if_rdata, 32'h77777777);
      if_req = 0;
      step();

      // MEM_LAT=1 with IF request held across its ack
      if_req1 = 1; if_addr1 = 16'h0044; rd_val1 = 32'hCAFE0001;
      step();
      chk("t6_c1_en", mem_en1, 1);
      chk("t6_c1_addr", mem_addr1, 16'h0044);
      step();
      chk("t6_c2_en", mem_en1, 0);
      chk("t6_c2_ack", if_ack1, 1);
      chk("t6_c2_rdata", if_rdata1, 32'hCAFE0001);
      rd_val1 = 32'hCAFE0002;
      step();
      chk("t6_c3_en", mem_en1, 0);
      chk("t6_c3_ack", if_ack1, 0);
      chk("t6_c3_busy", busy1, 0);
      step();
      chk("t6_c4_en", mem_en1, 1);
      step();
      chk("t6_c5_ack", if_ack1, 1);
      chk("t6_c5_rdata", if_rdata1, 32'hCAFE0002);
      if_req1 = 0;
      step(); step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
